// File: rtl/wb_pkg.sv
// Shared write-back definitions.
// Holds the datapath sizes, the control-flag bit indices carried down the pipeline
// (the memory stage imports the same indices) and the write-back FSM state type.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned NREGS  = 16;

  // Bit positions inside the 8-bit control-flag bundle.
  localparam int unsigned WB_SRC = 0;
  localparam int unsigned MEM_WR = 1;
  localparam int unsigned MEM_RD = 2;
  localparam int unsigned REG_WR = 5;
  localparam int unsigned HALT   = 6;

  typedef enum logic {
    StRun,
    StHalted
  } wb_state_e;

endpackage

// File: rtl/wb_stage_reg_file.sv
// General-purpose register file for the write-back stage.
// Ports:
//   clk, clear        clock and asynchronous active-low clear (zeroes every register)
//   we, waddr, wdata  synchronous write port
//   rs_addr/rs_data   asynchronous read port A
//   rt_addr/rt_data   asynchronous read port B
// There is no hard-wired zero register; every entry is writable.
module wb_stage_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rs_data = regs_q[rs_addr];
  assign rt_data = regs_q[rt_addr];

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage.
// Latches the memory-stage result into a stage register, commits it into the register
// file on the following unstalled edge, and serves two bypassed read ports to decode.
// Ports:
//   clk, clear                 clock, asynchronous active-low reset
//   turn_off                   stall: holds the stage register and suppresses commit
//   mem_out, rd_buf4, reg_wr3  result, destination and write enable from memory stage
//   cu_flags4                  control flags from memory stage (only HALT used)
//   rs_addr/rs_data,
//   rt_addr/rt_data            decode read ports, bypassed from the pending write
//   wb_valid, wb_rd, wb_data   pending write, for the hazard/forwarding unit
//   halted                     sticky, set when a HALT instruction commits
//   retire_cnt                 committed register writes, wraps
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned REG_AW = wb_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              turn_off,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [REG_AW-1:0] rd_buf4,
  input  logic              reg_wr3,
  input  logic [7:0]        cu_flags4,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  wb_state_e         state_q;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_halt_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic              halted_q;

  logic              advance;
  logic              commit;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;
  logic              bypass_en;

  // Only the HALT flag matters here; the rest are consumed upstream.
  logic unused_flags;
  assign unused_flags = ^{cu_flags4[7], cu_flags4[5:0]};

  assign advance = !turn_off && (state_q == StRun);
  assign commit  = advance && wb_valid_q;

  // Stage register, FSM and retire counter. The commit of the held instruction and
  // the load of the next one share the same edge.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= StRun;
      halted_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_halt_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (advance) begin
            wb_valid_q <= reg_wr3;
            wb_rd_q    <= rd_buf4;
            wb_data_q  <= mem_out;
            wb_halt_q  <= cu_flags4[HALT];
            if (wb_valid_q) begin
              retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
            if (wb_halt_q) begin
              state_q  <= StHalted;
              halted_q <= 1'b1;
            end
          end
        end
        StHalted: begin
          // Absorbing until clear; stage register and counter frozen.
        end
        default: state_q <= StRun;
      endcase
    end
  end

  wb_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .clear   (clear),
    .we      (commit),
    .waddr   (wb_rd_q),
    .wdata   (wb_data_q),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rf_rs_data),
    .rt_data (rf_rt_data)
  );

  // Bypass is disabled once halted: the frozen stage register will never commit.
  assign bypass_en = wb_valid_q && (state_q == StRun);

  assign rs_data = (bypass_en && (rs_addr == wb_rd_q)) ? wb_data_q : rf_rs_data;
  assign rt_data = (bypass_en && (rt_addr == wb_rd_q)) ? wb_data_q : rf_rt_data;

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign halted     = halted_q;
  assign retire_cnt = retire_cnt_q;

endmodule
